// File: rtl/rsa_uart_pkg.sv
// Shared types and constants for the RSA ciphertext UART transmitter.
package rsa_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int BAUD_DEF   = 115_200;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; rdata is the head whenever empty is low.
// Pointers carry an extra MSB so full and empty are distinguishable without a counter.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [7:0]               wdata,
  input  logic                     rd,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign usedw = wr_ptr - rd_ptr;
  assign full  = (usedw == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: queues bytes in a FIFO and shifts them out LSB first.
// A frame is popped from IDLE or on the last STOP cycle, so back-to-back frames have no gap.
module uart_tx_buffered
  import rsa_uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int BAUD   = BAUD_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_in,
  input  logic                   wr_req,
  output logic                   full,
  output logic [$clog2(DEPTH):0] usedw,
  output logic                   overflow,
  output logic                   busy,
  output logic                   tx
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);

  tx_state_e   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  fifo_q;
  logic        fifo_empty;
  logic        baud_last;
  logic        pop;

  assign baud_last = (baud_cnt == CW'(CPB - 1));
  assign pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_last));

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_req),
    .wdata (data_in),
    .rd    (pop),
    .rdata (fifo_q),
    .full  (full),
    .empty (fifo_empty),
    .usedw (usedw)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // full is sampled before this cycle's pop, so a pop never rescues a write
      if (wr_req && full) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift <= fifo_q;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_q;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: every cycle's outputs are compared with a frame-schedule model
// built from write times (frame k starts at max(write+1, previous start + frame length)).
module tb_uart_tx_buffered;
  import rsa_uart_pkg::*;

  localparam int CLK_HZ     = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int DEPTH      = 4;
  localparam int CPB        = CLK_HZ / BAUD;
  localparam int FRAME_CLKS = FRAME_BITS * CPB;
  localparam int UW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_in;
  logic          wr_req;
  logic          full;
  logic [UW-1:0] usedw;
  logic          overflow;
  logic          busy;
  logic          tx;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  // model state: accepted write edges, bytes and frame start edges since the last reset
  int         wt[$];
  int         fs[$];
  logic [7:0] qb[$];
  logic       m_ovf = 1'b0;

  logic [UW+3:0] got, exp;

  uart_tx_buffered #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .wr_req   (wr_req),
    .full     (full),
    .usedw    (usedw),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // {tx, busy, full, overflow, usedw} expected after edge t
  function automatic logic [UW+3:0] model_out(input int t);
    int used;
    int slot;
    logic tx_e;
    logic busy_e;
    used = 0;
    tx_e = 1'b1;
    busy_e = 1'b0;
    foreach (wt[k]) if (wt[k] <= t) used++;
    foreach (fs[k]) begin
      if (fs[k] <= t) used--;
      if (t >= fs[k] && t < fs[k] + FRAME_CLKS) begin
        busy_e = 1'b1;
        slot = (t - fs[k]) / CPB;
        if (slot == 0) tx_e = 1'b0;
        else if (slot <= 8) tx_e = qb[k][slot-1];
        else tx_e = 1'b1;
      end
    end
    return {tx_e, busy_e, used == DEPTH, m_ovf, UW'(used)};
  endfunction

  task automatic step(input logic rst_n, input logic w, input logic [7:0] d);
    logic [UW+3:0] prev;
    int start;
    reset = rst_n;
    wr_req = w;
    data_in = d;
    @(posedge clk);
    ecount++;
    if (!rst_n) begin
      wt.delete();
      fs.delete();
      qb.delete();
      m_ovf = 1'b0;
    end else if (w) begin
      prev = model_out(ecount - 1);
      if (int'(prev[UW-1:0]) < DEPTH) begin
        start = ecount + 1;
        if (fs.size() > 0 && fs[fs.size()-1] + FRAME_CLKS > start) start = fs[fs.size()-1] + FRAME_CLKS;
        wt.push_back(ecount);
        qb.push_back(d);
        fs.push_back(start);
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    apply_reset(3);
    got = {tx, busy, full, overflow, usedw};
    total++;
    if (got !== {4'b1000, UW'(0)}) begin
      bad++; $display("FAIL reset_state got=%b want=%b", got, {4'b1000, UW'(0)});
    end
    step(1'b1, 1'b0, 8'h00);
    got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_idle e=%0d got=%b want=%b", ecount, got, exp); end
  endtask

  task automatic test_single;
    int n;
    apply_reset(1);
    step(1'b1, 1'b1, 8'hA5);
    n = ecount;
    for (int i = 0; i < 110; i++) begin
      if (i > 0) step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL single e=%0d got=%b want=%b", ecount, got, exp); end
      if (ecount == n + 1) begin
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL single_start tx=%b busy=%b want tx=0 busy=1", tx, busy);
        end
      end
      if (ecount == n + 101) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end busy=%b want 0", busy); end
      end
    end
  endtask

  task automatic test_burst_overflow;
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, bytes[i]);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL burst e=%0d got=%b want=%b", ecount, got, exp); end
    end
    total++;
    if (full !== 1'b1 || overflow !== 1'b0 || usedw !== UW'(DEPTH)) begin
      bad++; $display("FAIL burst_full full=%b ovf=%b usedw=%0d want 1 0 %0d", full, overflow, usedw, DEPTH);
    end
    step(1'b1, 1'b1, 8'h66);
    total++;
    if (overflow !== 1'b1 || usedw !== UW'(DEPTH)) begin
      bad++; $display("FAIL overflow_set ovf=%b usedw=%0d want 1 %0d", overflow, usedw, DEPTH);
    end
    for (int i = 0; i < 5 * FRAME_CLKS + 20; i++) begin
      step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL burst_line e=%0d got=%b want=%b", ecount, got, exp); end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky ovf=%b want 1", overflow); end
  endtask

  task automatic test_simultaneous;
    int n;
    apply_reset(1);
    step(1'b1, 1'b1, 8'hC3);
    n = ecount;
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'h81);
    while (ecount < n + FRAME_CLKS) begin
      step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL simul_pre e=%0d got=%b want=%b", ecount, got, exp); end
    end
    total++;
    if (usedw !== UW'(2)) begin bad++; $display("FAIL simul_before usedw=%0d want 2", usedw); end
    step(1'b1, 1'b1, 8'h77);
    total++;
    if (usedw !== UW'(2) || tx !== 1'b0) begin
      bad++; $display("FAIL simul_pop usedw=%0d tx=%b want 2 0", usedw, tx);
    end
    for (int i = 0; i < 3 * FRAME_CLKS + 20; i++) begin
      step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL simul_line e=%0d got=%b want=%b", ecount, got, exp); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    apply_reset(1);
    step(1'b1, 1'b1, 8'h0F);
    n = ecount;
    step(1'b1, 1'b1, 8'h99);
    while (ecount < n + 44) begin
      step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL midrst_pre e=%0d got=%b want=%b", ecount, got, exp); end
    end
    step(1'b0, 1'b0, 8'h00);
    total++;
    if (tx !== 1'b1 || usedw !== UW'(0) || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_abort tx=%b usedw=%0d busy=%b want 1 0 0", tx, usedw, busy);
    end
    step(1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < FRAME_CLKS + 10; i++) begin
      step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL midrst_after e=%0d got=%b want=%b", ecount, got, exp); end
    end
  endtask

  task automatic test_random;
    int rate;
    logic w;
    apply_reset(1);
    for (int i = 0; i < 1200; i++) begin
      rate = (i < 300) ? 6 : 1;
      w = ($urandom_range(0, 99) < rate);
      step(1'b1, w, 8'($urandom()));
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL random e=%0d got=%b want=%b", ecount, got, exp); end
    end
    for (int i = 0; i < (DEPTH + 1) * FRAME_CLKS + 10; i++) begin
      step(1'b1, 1'b0, 8'h00);
      got = {tx, busy, full, overflow, usedw}; exp = model_out(ecount); total++;
      if (got !== exp) begin bad++; $display("FAIL random_drain e=%0d got=%b want=%b", ecount, got, exp); end
    end
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || usedw !== UW'(0)) begin
      bad++; $display("FAIL random_idle tx=%b busy=%b usedw=%0d want 1 0 0", tx, busy, usedw);
    end
  endtask

  initial begin
    reset = 1'b0;
    wr_req = 1'b0;
    data_in = 8'h00;
    test_reset;
    test_single;
    test_burst_overflow;
    test_simultaneous;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
